// File: rtl/jt12_wrq.sv
// jt12_wrq -- host write queue in front of the YM2612 register map stage.
//
// Host writes (cpu_wr) are queued as {cpu_addr, cpu_din} in a 2**AW entry
// FIFO. A small FSM drains the queue one entry at a time:
//   IDLE    -> pop head, load mmr_addr/mmr_din, raise mmr_write
//   ASSERT  -> mmr_write held high for HOLD cycles
//   RELEASE -> 2 cycles low so the downstream edge detector registers busy
//   WAIT    -> spacing before the next write
//
// Handshake: the host side has no ready; a cpu_wr seen while the registered
// full flag is set is dropped and latches ovf until ovf_clr. The downstream
// side is level based: mmr_write is a pulse of HOLD cycles, and mmr_addr /
// mmr_din stay stable from its rise until the next pop.
//
// Build option: JT12_WRQ_BUSYCHK_EN
//   defined   : WAIT ends on the first cycle with mmr_busy=0, or after a
//               255-cycle timeout if busy stays high.
//   undefined : mmr_busy is ignored; WAIT lasts GAP-2 cycles so the
//               mmr_write fall-to-rise spacing is exactly GAP cycles.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   cpu_wr/addr/din    host write strobe, address, data
//   ovf_clr            clears the sticky overflow flag
//   mmr_busy           busy from the register map stage
//   mmr_write/addr/din write level, address and data to the register map
//   full, level, ovf   FIFO full, occupancy, dropped-write flag
module jt12_wrq #(
  parameter int AW   = 4,
  parameter int HOLD = 2,
  parameter int GAP  = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          ovf_clr,
  input  logic          mmr_busy,
  output logic          mmr_write,
  output logic [1:0]    mmr_addr,
  output logic [7:0]    mmr_din,
  output logic          full,
  output logic [AW:0]   level,
  output logic          ovf
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, WAIT} state_t;

  state_t         state, state_nx;
  logic [7:0]     cnt, cnt_nx;
  logic           write_nx;
  logic           dispatch;
  logic           push, pop, drop;
  logic [AW:0]    level_nx;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [9:0]     mem [DEPTH];

  assign push     = cpu_wr & ~full;
  assign drop     = cpu_wr & full;
  assign level_nx = level + (AW+1)'(push) - (AW+1)'(pop);

  // dispatch means "behave as IDLE this cycle". WAIT (and RELEASE when the
  // wait is zero length) dispatch directly, so the next pulse can rise on
  // the very edge the spacing expires instead of one cycle later.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    write_nx = mmr_write;
    dispatch = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: dispatch = 1'b1;
      ASSERT: begin
        if (cnt == 8'd0) begin
          state_nx = RELEASE;
          write_nx = 1'b0;
          cnt_nx   = 8'd1;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      RELEASE: begin
        if (cnt == 8'd0) begin
`ifdef JT12_WRQ_BUSYCHK_EN
          state_nx = WAIT;
          cnt_nx   = 8'd254;
`else
          if (GAP <= 2) begin
            dispatch = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = (GAP > 2) ? 8'(GAP - 3) : 8'd0;
          end
`endif
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      WAIT: begin
`ifdef JT12_WRQ_BUSYCHK_EN
        if (!mmr_busy || cnt == 8'd0) dispatch = 1'b1;
        else                          cnt_nx = cnt - 8'd1;
`else
        if (cnt == 8'd0) dispatch = 1'b1;
        else             cnt_nx = cnt - 8'd1;
`endif
      end
      default: state_nx = IDLE;
    endcase
    if (dispatch) begin
      state_nx = IDLE;
      if (level != '0) begin
        pop      = 1'b1;
        state_nx = ASSERT;
        write_nx = 1'b1;
        cnt_nx   = 8'(HOLD - 1);
      end
    end
  end

  // Storage is not reset: stale entries are unreachable once the pointers
  // and level are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mmr_write <= 1'b0;
      mmr_addr  <= 2'd0;
      mmr_din   <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mmr_write <= write_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {mmr_addr, mmr_din} <= mem[rd_ptr];
        rd_ptr              <= rd_ptr + 1'b1;
      end
      level <= level_nx;
      full  <= (level_nx == (AW+1)'(DEPTH));
      // a drop wins over a simultaneous clear
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt12_wrq.sv
module tb_jt12_wrq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       ovf_clr;
  logic       mmr_busy;
  logic       mmr_write;
  logic [1:0] mmr_addr;
  logic [7:0] mmr_din;
  logic       full;
  logic [4:0] level;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  jt12_wrq #(.AW(4), .HOLD(2), .GAP(24)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .ovf_clr(ovf_clr), .mmr_busy(mmr_busy),
    .mmr_write(mmr_write), .mmr_addr(mmr_addr), .mmr_din(mmr_din),
    .full(full), .level(level), .ovf(ovf)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    cpu_wr  = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic put(input logic [1:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ticks until mmr_write is high; n = edges taken (bounded)
  task automatic wait_rise(output int n);
    n = 0;
    while (!mmr_write && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    while (mmr_write && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic count_rises(input int cycles, output int rises);
    logic prev;
    rises = 0;
    prev  = mmr_write;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mmr_write && !prev) rises++;
      prev = mmr_write;
    end
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic       exp_write;
    logic [1:0] exp_addr;
    logic [7:0] exp_din;
    logic [4:0] exp_level;
  } vec_t;

  vec_t tbl[30];

  initial begin
    int n;
    int r;
    cpu_wr   = 1'b0;
    cpu_addr = 2'd0;
    cpu_din  = 8'd0;
    ovf_clr  = 1'b0;
    mmr_busy = 1'b0;
    rst_n    = 1'b0;

    // ---------------- reset state
    do_reset();
    check("rst mmr_write", mmr_write, 0);
    check("rst mmr_addr", mmr_addr, 0);
    check("rst mmr_din", mmr_din, 0);
    check("rst level", level, 0);
    check("rst full", full, 0);
    check("rst ovf", ovf, 0);

`ifndef JT12_WRQ_BUSYCHK_EN
    // ---------------- table: single write, then queue during WAIT and
    // push+pop at level 3 on the edge the gap expires (fall e3 -> rise e27)
    for (int i = 0; i < 30; i++) begin
      tbl[i].wr        = 1'b0;
      tbl[i].addr      = 2'd0;
      tbl[i].din       = 8'd0;
      tbl[i].exp_write = (i == 1 || i == 2 || i == 27 || i == 28);
      tbl[i].exp_addr  = (i < 27) ? 2'd0 : 2'd1;
      tbl[i].exp_din   = (i == 0) ? 8'h00 : ((i < 27) ? 8'h28 : 8'hb1);
      tbl[i].exp_level = (i == 0) ? 5'd1 : (i < 10) ? 5'd0 : (i == 10) ? 5'd1 :
                         (i == 11) ? 5'd2 : 5'd3;
    end
    tbl[0].wr  = 1'b1; tbl[0].addr  = 2'd0; tbl[0].din  = 8'h28;
    tbl[10].wr = 1'b1; tbl[10].addr = 2'd1; tbl[10].din = 8'hb1;
    tbl[11].wr = 1'b1; tbl[11].addr = 2'd3; tbl[11].din = 8'hc2;
    tbl[12].wr = 1'b1; tbl[12].addr = 2'd2; tbl[12].din = 8'hd3;
    tbl[27].wr = 1'b1; tbl[27].addr = 2'd1; tbl[27].din = 8'he4;

    for (int i = 0; i < 30; i++) begin
      cpu_wr   = tbl[i].wr;
      cpu_addr = tbl[i].addr;
      cpu_din  = tbl[i].din;
      tick();
      check($sformatf("vec%0d mmr_write", i), mmr_write, tbl[i].exp_write);
      check($sformatf("vec%0d mmr_addr", i), mmr_addr, tbl[i].exp_addr);
      check($sformatf("vec%0d mmr_din", i), mmr_din, tbl[i].exp_din);
      check($sformatf("vec%0d level", i), level, tbl[i].exp_level);
      check($sformatf("vec%0d ovf", i), ovf, 0);
    end
    cpu_wr = 1'b0;

    // fall-to-rise spacing for the remaining C, D, E entries
    wait_rise(n);
    check("gap C", n, 24);
    check("din C", mmr_din, 8'hc2);
    check("addr C", mmr_addr, 2'd3);
    wait_fall();
    wait_rise(n);
    check("gap D", n, 24);
    check("din D", mmr_din, 8'hd3);
    wait_fall();
    wait_rise(n);
    check("gap E", n, 24);
    check("din E", mmr_din, 8'he4);
    wait_fall();
    count_rises(80, r);
    check("empty no pulse", r, 0);
    check("drained level", level, 0);
`else
    // ---------------- busy gating
    mmr_busy = 1'b1;
    put(2'd0, 8'h11);
    tick();
    put(2'd1, 8'h22);
    tick();
    cpu_wr = 1'b0;
    check("busy first rise", mmr_write, 1);
    check("busy first din", mmr_din, 8'h11);
    tick();
    tick();
    check("busy first fall", mmr_write, 0);
    count_rises(40, r);
    check("busy held no pulse", r, 0);
    mmr_busy = 1'b0;
    tick();
    check("busy release rise", mmr_write, 1);
    check("busy release din", mmr_din, 8'h22);
    mmr_busy = 1'b1;
    put(2'd2, 8'h33);
    tick();
    cpu_wr = 1'b0;
    wait_fall();
    wait_rise(n);
    check("timeout gap", n, 257);
    check("timeout din", mmr_din, 8'h33);

    // push+pop on the busy-release edge at level 3
    wait_fall();
    put(2'd0, 8'h41); tick();
    put(2'd1, 8'h42); tick();
    put(2'd2, 8'h43); tick();
    cpu_wr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pp level before", level, 3);
    put(2'd3, 8'h44);
    mmr_busy = 1'b0;
    tick();
    cpu_wr = 1'b0;
    check("pp mmr_write", mmr_write, 1);
    check("pp level", level, 3);
    check("pp ovf", ovf, 0);
    check("pp din", mmr_din, 8'h41);
`endif

    // ---------------- burst of 20 into a 16-deep queue
    do_reset();
    mmr_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put(2'(i), 8'(i));
      tick();
      if (i == 15) check("burst full@16", full, 0);
      if (i == 16) begin
        check("burst full@17", full, 1);
        check("burst level@17", level, 16);
        check("burst ovf@17", ovf, 0);
      end
    end
    check("burst level end", level, 16);
    check("burst ovf end", ovf, 1);
    cpu_wr  = 1'b0;
    ovf_clr = 1'b1;
    tick();
    check("ovf_clr", ovf, 0);
    cpu_wr = 1'b1;
    tick();
    check("drop beats clr", ovf, 1);
    check("drop level", level, 16);
    cpu_wr = 1'b0;
    tick();
    check("ovf_clr again", ovf, 0);
    ovf_clr = 1'b0;
`ifndef JT12_WRQ_BUSYCHK_EN
    for (int i = 0; i < 4; i++) tick();
`else
    mmr_busy = 1'b0;
`endif
    // drop while full even though a pop happens on the same edge
    put(2'd3, 8'hff);
    tick();
    cpu_wr = 1'b0;
    check("pop+drop write", mmr_write, 1);
    check("pop+drop level", level, 15);
    check("pop+drop ovf", ovf, 1);
    check("pop+drop din", mmr_din, 8'd1);

    // ---------------- reset during ASSERT with 5 entries queued
    do_reset();
    mmr_busy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      put(2'(i), 8'(i));
      tick();
    end
    cpu_wr = 1'b0;
    wait_rise(n);
    check("mid second pulse din", mmr_din, 8'd1);
    check("mid queued level", level, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid rst mmr_write", mmr_write, 0);
    check("mid rst level", level, 0);
    check("mid rst full", full, 0);
    count_rises(300, r);
    check("after rst no pulse", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
